// File: rtl/square_wave_meas.sv
// Square-wave period / high-time meter: counts clk cycles between rising edges and
// from rise to fall, strobing o_valid per completed wave cycle. Optional macro SQW_MEAS_SYNC_EN.
module square_wave_meas (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_clear,
    input  logic        i_wave_in,
    output logic [15:0] o_period,
    output logic [15:0] o_high_time,
    output logic        o_valid,
    output logic        o_locked,
    output logic        o_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_in_q;
    logic        r_prev_q;
    logic [15:0] r_cnt;
    logic [15:0] r_hi_cnt;
    logic [15:0] r_period;
    logic [15:0] r_high_time;
    logic        r_valid;
    logic        r_locked;
    logic        r_timeout;

    logic        w_wave_src;
    logic        w_rise;
    logic        w_fall;
    logic        w_edge;
    logic        w_cnt_sat;

`ifdef SQW_MEAS_SYNC_EN
    // Two-flop synchronizer for sources not related to i_clk.
    logic r_sync_0;
    logic r_sync_1;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync_0 <= 1'b0;
            r_sync_1 <= 1'b0;
        end else begin
            r_sync_0 <= i_wave_in;
            r_sync_1 <= r_sync_0;
        end
    end

    assign w_wave_src = r_sync_1;
`else
    assign w_wave_src = i_wave_in;
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_in_q   <= 1'b0;
            r_prev_q <= 1'b0;
        end else begin
            r_in_q   <= w_wave_src;
            r_prev_q <= r_in_q;
        end
    end

    assign w_rise    = r_in_q & ~r_prev_q;
    assign w_fall    = ~r_in_q & r_prev_q;
    assign w_edge    = w_rise | w_fall;
    assign w_cnt_sat = (r_cnt == 16'hFFFF);

    // Free-running phase counter: restarts at 1 on every rise, sticks at all-ones.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt <= 16'd0;
        end else if (w_rise) begin
            r_cnt <= 16'd1;
        end else if (!w_cnt_sat) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= ST_IDLE;
            r_hi_cnt    <= 16'd0;
            r_period    <= 16'd0;
            r_high_time <= 16'd0;
            r_valid     <= 1'b0;
            r_locked    <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (i_clear) begin
                // A rise coinciding with clear is deliberately dropped.
                r_state   <= ST_IDLE;
                r_locked  <= 1'b0;
                r_timeout <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_rise) begin
                            r_state <= ST_HIGH;
                        end
                    end
                    ST_HIGH: begin
                        if (w_fall) begin
                            r_hi_cnt <= r_cnt;
                            r_state  <= ST_LOW;
                        end else if (w_cnt_sat && !w_edge) begin
                            r_state   <= ST_IDLE;
                            r_timeout <= 1'b1;
                            r_locked  <= 1'b0;
                        end
                    end
                    ST_LOW: begin
                        if (w_rise) begin
                            r_period    <= r_cnt;
                            r_high_time <= r_hi_cnt;
                            r_valid     <= 1'b1;
                            r_locked    <= 1'b1;
                            r_timeout   <= 1'b0;
                            r_state     <= ST_HIGH;
                        end else if (w_cnt_sat && !w_edge) begin
                            r_state   <= ST_IDLE;
                            r_timeout <= 1'b1;
                            r_locked  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_period    = r_period;
    assign o_high_time = r_high_time;
    assign o_valid     = r_valid;
    assign o_locked    = r_locked;
    assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_square_wave_meas.sv
// Directed bench for square_wave_meas: table of wave cycles with expected reports,
// plus hand sequences for reset mid-measurement, clear-on-rise and timeout.
module tb_square_wave_meas;

`ifdef SQW_MEAS_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clear;
    logic        wave;
    logic [15:0] period;
    logic [15:0] high_time;
    logic        valid;
    logic        locked;
    logic        timeout;

    int errors = 0;
    int checks = 0;

    // One record = one wave cycle driven (hi steps high, lo steps low) and what the
    // DUT must report inside that window (the rise opening it closes the previous cycle).
    typedef struct {
        int hi;
        int lo;
        int exp_nv;
        int exp_p;
        int exp_h;
        int exp_lock;
        int exp_to;
    } vec_t;

    vec_t vecs [15];

    square_wave_meas dut (
        .i_clk       (clk),
        .i_reset_n   (reset_n),
        .i_clear     (clear),
        .i_wave_in   (wave),
        .o_period    (period),
        .o_high_time (high_time),
        .o_valid     (valid),
        .o_locked    (locked),
        .o_timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_row(input int idx);
        int nv;
        int vstep;
        int unstable;
        int pp;
        int ph;
        nv       = 0;
        vstep    = -1;
        unstable = 0;
        pp       = int'(period);
        ph       = int'(high_time);
        for (int s = 1; s <= vecs[idx].hi + vecs[idx].lo; s++) begin
            wave = (s <= vecs[idx].hi);
            step();
            if (valid) begin
                nv++;
                if (vstep < 0) vstep = s;
            end else if (int'(period) != pp || int'(high_time) != ph) begin
                unstable++;
            end
            pp = int'(period);
            ph = int'(high_time);
        end
        check($sformatf("row%0d nvalid", idx), nv, vecs[idx].exp_nv);
        if (vecs[idx].exp_nv > 0)
            check($sformatf("row%0d valid_step", idx), vstep, 2 + LAT);
        check($sformatf("row%0d period", idx), int'(period), vecs[idx].exp_p);
        check($sformatf("row%0d high_time", idx), int'(high_time), vecs[idx].exp_h);
        check($sformatf("row%0d locked", idx), int'(locked), vecs[idx].exp_lock);
        check($sformatf("row%0d timeout", idx), int'(timeout), vecs[idx].exp_to);
        check($sformatf("row%0d held_between_valid", idx), unstable, 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " period"}, int'(period), 0);
        check({tag, " high_time"}, int'(high_time), 0);
        check({tag, " valid"}, int'(valid), 0);
        check({tag, " locked"}, int'(locked), 0);
        check({tag, " timeout"}, int'(timeout), 0);
    endtask

    initial begin
        int nv;

        //            hi lo nv  p   h  lk to
        vecs[0]  = '{3, 7, 0,  0,  0, 0, 0};   // first rise only arms
        vecs[1]  = '{3, 7, 1, 10,  3, 1, 0};
        vecs[2]  = '{3, 7, 1, 10,  3, 1, 0};
        vecs[3]  = '{3, 2, 1, 10,  3, 1, 0};   // cut-short cycle
        vecs[4]  = '{1, 3, 1,  5,  3, 1, 0};   // transitional report
        vecs[5]  = '{1, 3, 1,  4,  1, 1, 0};
        vecs[6]  = '{1, 3, 1,  4,  1, 1, 0};
        vecs[7]  = '{3, 7, 1,  4,  1, 1, 0};
        vecs[8]  = '{3, 7, 0,  0,  0, 0, 0};   // after reset: re-arm
        vecs[9]  = '{3, 7, 1, 10,  3, 1, 0};
        vecs[10] = '{3, 7, 1, 10,  3, 1, 0};
        vecs[11] = '{3, 7, 0, 10,  3, 0, 0};   // after clear: re-arm, values kept
        vecs[12] = '{3, 7, 1, 10,  3, 1, 0};
        vecs[13] = '{3, 7, 0, 10,  3, 0, 1};   // after timeout: still sticky
        vecs[14] = '{3, 7, 1, 10,  3, 1, 0};

        reset_n = 1'b0;
        clear   = 1'b0;
        wave    = 1'b0;
        repeat (2) step();
        check_zero("reset");
        reset_n = 1'b1;
        step();

        for (int i = 0; i <= 7; i++) run_row(i);

        // Reset asserted while in LOW of a running measurement.
        wave = 1'b1;
        repeat (3) step();
        wave = 1'b0;
        repeat (3) step();
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("rst_mid");
        step();
        check_zero("rst_held");
        reset_n = 1'b1;
        repeat (2) step();

        for (int i = 8; i <= 10; i++) run_row(i);

        // Clear lands in the same cycle as the rise: that edge must be ignored.
        nv = 0;
        for (int s = 1; s <= 10; s++) begin
            wave  = (s <= 3);
            clear = (s == 2 + LAT);
            step();
            if (valid) nv++;
        end
        clear = 1'b0;
        check("clear nvalid", nv, 0);
        check("clear locked", int'(locked), 0);
        check("clear period_kept", int'(period), 10);
        check("clear high_kept", int'(high_time), 3);

        for (int i = 11; i <= 12; i++) run_row(i);

        // Wave stuck high: timeout fires exactly when the phase passes 65535 cycles.
        wave = 1'b1;
        for (int s = 1; s <= 65537 + LAT; s++) begin
            step();
            if (s == 65536 + LAT) begin
                check("to_edge timeout_before", int'(timeout), 0);
                check("to_edge locked_before", int'(locked), 1);
            end
            if (s == 65537 + LAT) begin
                check("to_edge timeout_after", int'(timeout), 1);
                check("to_edge locked_after", int'(locked), 0);
                check("to_edge period_hold", int'(period), 10);
                check("to_edge high_hold", int'(high_time), 3);
            end
        end
        wave = 1'b0;
        repeat (3) step();

        for (int i = 13; i <= 14; i++) run_row(i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
